// File: rtl/raster_pkg.sv
// Shared rasterizer definitions: controller state encoding, coordinate/edge widths,
// default screen size and the standard 2-D edge function.
package raster_pkg;

   localparam int COORD_W      = 16;
   localparam int EDGE_W       = 36;
   localparam int SCREEN_W_DEF = 320;
   localparam int SCREEN_H_DEF = 240;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SCAN,
      ST_DRAIN,
      ST_DONE
   } state_e;

   typedef logic signed [COORD_W-1:0] coord_t;
   typedef logic signed [EDGE_W-1:0]  edge_t;

   typedef struct packed {
      coord_t x;
      coord_t y;
   } vertex_t;

   // E(a,b,p) = (bx-ax)*(py-ay) - (px-ax)*(by-ay), exact at every stage.
   function automatic edge_t edge_fn(input vertex_t a, input vertex_t b, input vertex_t p);
      logic signed [COORD_W:0]     dbx, dby, dpx, dpy;
      logic signed [2*COORD_W+1:0] m0, m1;
      edge_t                       e0, e1;
      dbx = {b.x[COORD_W-1], b.x} - {a.x[COORD_W-1], a.x};
      dby = {b.y[COORD_W-1], b.y} - {a.y[COORD_W-1], a.y};
      dpx = {p.x[COORD_W-1], p.x} - {a.x[COORD_W-1], a.x};
      dpy = {p.y[COORD_W-1], p.y} - {a.y[COORD_W-1], a.y};
      m0  = dbx * dpy;
      m1  = dpx * dby;
      e0  = EDGE_W'(m0);
      e1  = EDGE_W'(m1);
      return e0 - e1;
   endfunction

   function automatic coord_t min3(input coord_t a, input coord_t b, input coord_t c);
      coord_t m;
      m = (a < b) ? a : b;
      return (c < m) ? c : m;
   endfunction

   function automatic coord_t max3(input coord_t a, input coord_t b, input coord_t c);
      coord_t m;
      m = (a > b) ? a : b;
      return (c > m) ? c : m;
   endfunction

endpackage

// File: rtl/bbox_scanner.sv
// Row-major x/y walker over a bounding box; bounds are captured on load and
// the position steps only when advance is asserted.
module bbox_scanner
   import raster_pkg::*;
(
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               load_i,
   input  logic               advance_i,
   input  logic [COORD_W-1:0] xmin_i,
   input  logic [COORD_W-1:0] xmax_i,
   input  logic [COORD_W-1:0] ymin_i,
   input  logic [COORD_W-1:0] ymax_i,
   output logic [COORD_W-1:0] x_o,
   output logic [COORD_W-1:0] y_o,
   output logic               last_o
);

   logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
   logic [COORD_W-1:0] xmin_q, xmin_d, xmax_q, xmax_d, ymax_q, ymax_d;

   always_comb begin
      x_d    = x_q;
      y_d    = y_q;
      xmin_d = xmin_q;
      xmax_d = xmax_q;
      ymax_d = ymax_q;
      if (load_i) begin
         x_d    = xmin_i;
         y_d    = ymin_i;
         xmin_d = xmin_i;
         xmax_d = xmax_i;
         ymax_d = ymax_i;
      end else if (advance_i) begin
         if (x_q == xmax_q) begin
            x_d = xmin_q;
            y_d = y_q + COORD_W'(1);
         end else begin
            x_d = x_q + COORD_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         x_q    <= '0;
         y_q    <= '0;
         xmin_q <= '0;
         xmax_q <= '0;
         ymax_q <= '0;
      end else begin
         x_q    <= x_d;
         y_q    <= y_d;
         xmin_q <= xmin_d;
         xmax_q <= xmax_d;
         ymax_q <= ymax_d;
      end
   end

   assign x_o    = x_q;
   assign y_o    = y_q;
   assign last_o = (x_q == xmax_q) && (y_q == ymax_q);

endmodule

// File: rtl/tri_raster_ctrl.sv
// Triangle rasterization controller: clamps the bbox, walks it with bbox_scanner
// and streams covered pixels through a single valid/ready output register.
module tri_raster_ctrl
   import raster_pkg::*;
#(
   parameter int SCREEN_W = SCREEN_W_DEF,
   parameter int SCREEN_H = SCREEN_H_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               tri_valid,
   output logic               tri_ready,
   input  logic signed [COORD_W-1:0] v0x,
   input  logic signed [COORD_W-1:0] v0y,
   input  logic signed [COORD_W-1:0] v1x,
   input  logic signed [COORD_W-1:0] v1y,
   input  logic signed [COORD_W-1:0] v2x,
   input  logic signed [COORD_W-1:0] v2y,
   output logic               pix_valid,
   input  logic               pix_ready,
   output logic [COORD_W-1:0] pix_x,
   output logic [COORD_W-1:0] pix_y,
   output logic               busy,
   output logic               done
);

   localparam coord_t X_LIM = COORD_W'(SCREEN_W - 1);
   localparam coord_t Y_LIM = COORD_W'(SCREEN_H - 1);

   state_e             state_q, state_d;
   vertex_t            v0_q, v0_d, v1_q, v1_d, v2_q, v2_d;
   logic               neg_q, neg_d;
   logic               pix_valid_q, pix_valid_d;
   logic [COORD_W-1:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;

   edge_t              area, w0, w1, w2;
   coord_t             lo_x, hi_x, lo_y, hi_y;
   coord_t             bb_xmin, bb_xmax, bb_ymin, bb_ymax;
   logic               empty, covered, adv;
   logic               scan_load, scan_adv, scan_last;
   logic [COORD_W-1:0] scan_x, scan_y;
   vertex_t            pt;

   assign area = edge_fn(v0_q, v1_q, v2_q);

   // Bbox is clamped to the screen; an off-screen triangle ends up with min > max.
   always_comb begin
      lo_x    = min3(v0_q.x, v1_q.x, v2_q.x);
      hi_x    = max3(v0_q.x, v1_q.x, v2_q.x);
      lo_y    = min3(v0_q.y, v1_q.y, v2_q.y);
      hi_y    = max3(v0_q.y, v1_q.y, v2_q.y);
      bb_xmin = lo_x[COORD_W-1] ? '0 : lo_x;
      bb_ymin = lo_y[COORD_W-1] ? '0 : lo_y;
      bb_xmax = (hi_x > X_LIM) ? X_LIM : hi_x;
      bb_ymax = (hi_y > Y_LIM) ? Y_LIM : hi_y;
   end

   assign empty = (area == '0) || (bb_xmin > bb_xmax) || (bb_ymin > bb_ymax);

   assign pt = {scan_x, scan_y};
   assign w0 = edge_fn(v1_q, v2_q, pt);
   assign w1 = edge_fn(v2_q, v0_q, pt);
   assign w2 = edge_fn(v0_q, v1_q, pt);

   // Inclusive edges: zero counts as inside for either winding.
   always_comb begin
      if (neg_q)
         covered = (w0[EDGE_W-1] || (w0 == '0)) &&
                   (w1[EDGE_W-1] || (w1 == '0)) &&
                   (w2[EDGE_W-1] || (w2 == '0));
      else
         covered = !w0[EDGE_W-1] && !w1[EDGE_W-1] && !w2[EDGE_W-1];
   end

   assign adv = !pix_valid_q || pix_ready;

   bbox_scanner u_scanner (
      .clk_i     (clk),
      .rst_i     (rst),
      .load_i    (scan_load),
      .advance_i (scan_adv),
      .xmin_i    (bb_xmin),
      .xmax_i    (bb_xmax),
      .ymin_i    (bb_ymin),
      .ymax_i    (bb_ymax),
      .x_o       (scan_x),
      .y_o       (scan_y),
      .last_o    (scan_last)
   );

   always_comb begin
      state_d     = state_q;
      v0_d        = v0_q;
      v1_d        = v1_q;
      v2_d        = v2_q;
      neg_d       = neg_q;
      pix_valid_d = pix_valid_q;
      pix_x_d     = pix_x_q;
      pix_y_d     = pix_y_q;
      scan_load   = 1'b0;
      scan_adv    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (tri_valid) begin
               v0_d    = {v0x, v0y};
               v1_d    = {v1x, v1y};
               v2_d    = {v2x, v2y};
               state_d = ST_SETUP;
            end
         end
         ST_SETUP: begin
            neg_d = area[EDGE_W-1];
            if (empty) begin
               state_d = ST_DONE;
            end else begin
               scan_load = 1'b1;
               state_d   = ST_SCAN;
            end
         end
         ST_SCAN: begin
            if (adv) begin
               scan_adv    = 1'b1;
               pix_valid_d = covered;
               if (covered) begin
                  pix_x_d = scan_x;
                  pix_y_d = scan_y;
               end
               // An uncovered final pixel leaves the register empty, so skip DRAIN.
               if (scan_last)
                  state_d = covered ? ST_DRAIN : ST_DONE;
            end
         end
         ST_DRAIN: begin
            if (adv) begin
               pix_valid_d = 1'b0;
               state_d     = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         v0_q        <= '0;
         v1_q        <= '0;
         v2_q        <= '0;
         neg_q       <= 1'b0;
         pix_valid_q <= 1'b0;
         pix_x_q     <= '0;
         pix_y_q     <= '0;
      end else begin
         state_q     <= state_d;
         v0_q        <= v0_d;
         v1_q        <= v1_d;
         v2_q        <= v2_d;
         neg_q       <= neg_d;
         pix_valid_q <= pix_valid_d;
         pix_x_q     <= pix_x_d;
         pix_y_q     <= pix_y_d;
      end
   end

   assign tri_ready = (state_q == ST_IDLE) && !rst;
   assign busy      = (state_q == ST_SETUP) || (state_q == ST_SCAN) || (state_q == ST_DRAIN);
   assign done      = (state_q == ST_DONE);
   assign pix_valid = pix_valid_q;
   assign pix_x     = pix_x_q;
   assign pix_y     = pix_y_q;

endmodule

// File: tb/tb_tri_raster_ctrl.sv
// Scoreboard bench for tri_raster_ctrl: directed and random triangles against
// a plain-arithmetic coverage model, with a decoupled output monitor.
module tb_tri_raster_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        tri_valid;
   logic        tri_ready;
   logic [15:0] v0x, v0y, v1x, v1y, v2x, v2y;
   logic        pix_valid;
   logic        pix_ready;
   logic [15:0] pix_x, pix_y;
   logic        busy;
   logic        done;

   tri_raster_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .tri_valid (tri_valid),
      .tri_ready (tri_ready),
      .v0x       (v0x),
      .v0y       (v0y),
      .v1x       (v1x),
      .v1y       (v1y),
      .v2x       (v2x),
      .v2y       (v2y),
      .pix_valid (pix_valid),
      .pix_ready (pix_ready),
      .pix_x     (pix_x),
      .pix_y     (pix_y),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int          nChecks = 0;
   int          nPass   = 0;
   int unsigned expQ[$];
   int          hsCount, doneCnt, doneCyc, firstValidCyc, readyRiseCyc, acceptCyc, expCount;
   int unsigned firstPix;
   bit          seenValid, inFlight, prevStall, prevReady, randReady;
   logic [15:0] prevX, prevY;

   function automatic void check(string name, longint got, longint want);
      nChecks++;
      if (got == want) nPass++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", name, got, want);
   endfunction

   // Reference coverage model: brute-force over the clamped bbox using the edge equation.
   function automatic longint edgeF(longint ax, longint ay, longint bx, longint by,
                                    longint px, longint py);
      return (bx - ax) * (py - ay) - (px - ax) * (by - ay);
   endfunction

   function automatic int modelPush(int ax, int ay, int bx, int by, int cx, int cy);
      longint area, e0, e1, e2;
      int xl, xh, yl, yh, n;
      bit in;
      n    = 0;
      area = edgeF(ax, ay, bx, by, cx, cy);
      if (area == 0) return 0;
      xl = (ax < bx) ? ax : bx;  xl = (cx < xl) ? cx : xl;  if (xl < 0) xl = 0;
      yl = (ay < by) ? ay : by;  yl = (cy < yl) ? cy : yl;  if (yl < 0) yl = 0;
      xh = (ax > bx) ? ax : bx;  xh = (cx > xh) ? cx : xh;  if (xh > 319) xh = 319;
      yh = (ay > by) ? ay : by;  yh = (cy > yh) ? cy : yh;  if (yh > 239) yh = 239;
      for (int y = yl; y <= yh; y++) begin
         for (int x = xl; x <= xh; x++) begin
            e0 = edgeF(bx, by, cx, cy, x, y);
            e1 = edgeF(cx, cy, ax, ay, x, y);
            e2 = edgeF(ax, ay, bx, by, x, y);
            in = (area > 0) ? (e0 >= 0 && e1 >= 0 && e2 >= 0)
                            : (e0 <= 0 && e1 <= 0 && e2 <= 0);
            if (in) begin
               expQ.push_back({x[15:0], y[15:0]});
               n++;
            end
         end
      end
      return n;
   endfunction

   // Monitor: pops the scoreboard on every handshake and tracks timing landmarks.
   always @(negedge clk) begin
      if (rst) begin
         prevStall = 1'b0;
         prevReady = 1'b0;
      end else begin
         if (prevStall) begin
            check("hold_valid", pix_valid, 1);
            check("hold_xy", {pix_x, pix_y}, {prevX, prevY});
         end
         if (pix_valid && !seenValid) begin
            seenValid     = 1'b1;
            firstValidCyc = cyc;
            firstPix      = {pix_x, pix_y};
         end
         if (pix_valid) begin
            check("x_range", pix_x < 320, 1);
            check("y_range", pix_y < 240, 1);
         end
         if (pix_valid && pix_ready) begin
            if (expQ.size() == 0) check("pix_unexpected", {pix_x, pix_y}, -1);
            else check("pix_xy", {pix_x, pix_y}, expQ.pop_front());
            hsCount++;
         end
         if (inFlight) begin
            check("ready_low", tri_ready, 0);
            check("busy_vs_done", busy, !done);
         end
         if (done) begin
            doneCnt++;
            doneCyc  = cyc;
            inFlight = 1'b0;
         end
         if (tri_ready && !prevReady) readyRiseCyc = cyc;
         prevReady = tri_ready;
         prevStall = pix_valid && !pix_ready;
         prevX     = pix_x;
         prevY     = pix_y;
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (randReady) pix_ready = ($urandom_range(0, 3) != 0);
      end
   end

   task automatic applyStimulus(int ax, int ay, int bx, int by, int cx, int cy);
      int w = 0;
      @(posedge clk);
      #1;
      while (!tri_ready && w < 3000) begin
         @(posedge clk);
         #1;
         w++;
      end
      check("accept_ready", tri_ready, 1);
      v0x = 16'(ax);  v0y = 16'(ay);
      v1x = 16'(bx);  v1y = 16'(by);
      v2x = 16'(cx);  v2y = 16'(cy);
      expCount  = modelPush(ax, ay, bx, by, cx, cy);
      seenValid = 1'b0;
      hsCount   = 0;
      acceptCyc = cyc;
      tri_valid = 1'b1;
      @(posedge clk);
      #1;
      tri_valid = 1'b0;
      inFlight  = 1'b1;
      v0x = 16'($urandom);  v0y = 16'($urandom);
      v1x = 16'($urandom);  v1y = 16'($urandom);
      v2x = 16'($urandom);  v2y = 16'($urandom);
   endtask

   task automatic checkOutput(int budget);
      int start = doneCnt;
      int w     = 0;
      while (doneCnt == start && w < budget) begin
         @(negedge clk);
         #1;
         w++;
      end
      check("done_seen", doneCnt - start, 1);
      @(negedge clk);
      #1;
      check("done_pulse", done, 0);
      check("ready_after_done", readyRiseCyc, doneCyc + 1);
      check("queue_empty", expQ.size(), 0);
      check("pix_count", hsCount, expCount);
   endtask

   task automatic waitHandshakes(int n);
      int w = 0;
      while (hsCount < n && w < 500) begin
         @(negedge clk);
         #1;
         w++;
      end
      check("hs_reached", hsCount >= n, 1);
   endtask

   initial begin
      int dstart;
      rst = 1'b1;  tri_valid = 1'b0;  pix_ready = 1'b1;  randReady = 1'b0;
      v0x = '0;  v0y = '0;  v1x = '0;  v1y = '0;  v2x = '0;  v2y = '0;
      doneCnt = 0;  hsCount = 0;  inFlight = 1'b0;  seenValid = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("rst_ready", tri_ready, 0);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_ready", tri_ready, 1);
      check("post_rst_valid", pix_valid, 0);
      check("post_rst_busy", busy, 0);
      check("post_rst_done", done, 0);
      check("post_rst_xy", {pix_x, pix_y}, 0);

      $display("[TB] basic coverage");
      applyStimulus(0, 0, 4, 0, 0, 4);
      checkOutput(200);
      check("basic_count", hsCount, 15);
      check("basic_first_cyc", firstValidCyc - acceptCyc, 3);
      check("basic_done_cyc", doneCyc - acceptCyc, 27);
      check("basic_first_pix", firstPix, 0);

      $display("[TB] winding independence");
      applyStimulus(0, 0, 0, 4, 4, 0);
      checkOutput(200);
      check("wind_count", hsCount, 15);
      check("wind_done_cyc", doneCyc - acceptCyc, 27);

      $display("[TB] degenerate");
      applyStimulus(0, 0, 2, 2, 4, 4);
      checkOutput(50);
      check("degen_no_valid", seenValid, 0);
      check("degen_done_cyc", doneCyc - acceptCyc, 2);
      check("degen_ready_cyc", readyRiseCyc - acceptCyc, 3);

      $display("[TB] backpressure");
      applyStimulus(0, 0, 4, 0, 0, 4);
      waitHandshakes(4);
      @(posedge clk);
      #1;
      pix_ready = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      pix_ready = 1'b1;
      checkOutput(300);
      check("bp_count", hsCount, 15);
      check("bp_done_cyc", doneCyc - acceptCyc, 37);

      $display("[TB] clamping");
      applyStimulus(-5, -5, 20, -5, -5, 20);
      checkOutput(2000);
      check("clamp_lo_first", firstPix, 0);
      applyStimulus(300, 220, 400, 220, 300, 300);
      checkOutput(2000);
      check("clamp_hi_first", firstPix, {16'd300, 16'd220});

      $display("[TB] reset mid-scan");
      applyStimulus(0, 0, 4, 0, 0, 4);
      waitHandshakes(3);
      @(posedge clk);
      #1;
      rst = 1'b1;
      expQ.delete();
      inFlight = 1'b0;
      dstart   = doneCnt;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("mid_rst_valid", pix_valid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done, 0);
      repeat (3) @(negedge clk);
      check("mid_rst_no_done", doneCnt - dstart, 0);
      applyStimulus(0, 0, 1, 0, 0, 1);
      checkOutput(100);
      check("small_count", hsCount, 3);

      $display("[TB] random triangles");
      randReady = 1'b1;
      for (int i = 0; i < 25; i++) begin
         applyStimulus(int'($urandom_range(0, 44)) - 20, int'($urandom_range(0, 44)) - 20,
                       int'($urandom_range(0, 44)) - 20, int'($urandom_range(0, 44)) - 20,
                       int'($urandom_range(0, 44)) - 20, int'($urandom_range(0, 44)) - 20);
         checkOutput(3000);
      end
      randReady = 1'b0;
      @(posedge clk);
      #1;
      pix_ready = 1'b1;

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

   initial begin
      #900000;
      $display("[TB] FAIL watchdog: simulation did not complete, passed %0d of %0d", nPass, nChecks);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/tri_raster_ctrl.md
# tri_raster_ctrl

Triangle rasterization controller that sequences edge-function evaluation over a clamped screen bounding box. It accepts one triangle (three vertices) per handshake, scans every pixel of the bounding box in row-major order, and emits covered pixel coordinates on a valid/ready stream. It sits between the vertex/setup stage and the fragment/framebuffer write stage, and reuses the team's standard 2-D edge function.

## Interface
- SCREEN_W, 320, screen width in pixels; x is clamped to 0..SCREEN_W-1.
- SCREEN_H, 240, screen height in pixels; y is clamped to 0..SCREEN_H-1.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- tri_valid  in  1  triangle offered.
- tri_ready  out  1  controller idle and able to accept a triangle.
- v0x, v0y, v1x, v1y, v2x, v2y  in  16 each  vertex coordinates, signed two's complement.
- pix_valid  out  1  pix_x/pix_y hold a covered pixel.
- pix_ready  in  1  downstream accepts the pixel.
- pix_x, pix_y  out  16 each  covered pixel coordinate, unsigned.
- busy  out  1  a triangle is in progress (SETUP, SCAN or DRAIN).
- done  out  1  one-cycle pulse when a triangle finishes, including degenerate triangles.

## Operation
- Edge function: E(a,b,p) = (bx-ax)*(py-ay) - (px-ax)*(by-ay).
  - Differences are sign-extended to 17 bits and products are 34 bits.
  - The result is 36-bit signed. No truncation anywhere.
- States: IDLE, SETUP, SCAN, DRAIN, DONE.
- **IDLE**
  - tri_ready=1.
  - On tri_valid&&tri_ready: latch the vertices and go to SETUP.
- **SETUP** (1 cycle)
  - Compute area = E(v0,v1,v2) and sign flag neg = area<0.
  - Compute the bbox: xmin = max(min(vx),0), xmax = min(max(vx),SCREEN_W-1); same for y with SCREEN_H.
  - If area==0, xmin>xmax or ymin>ymax: go to DONE with no pixels.
  - Otherwise load the scanner with (xmin,ymin) and go to SCAN.
- **SCAN**
  - Each advancing cycle, evaluate w0=E(v1,v2,p), w1=E(v2,v0,p) and w2=E(v0,v1,p) at the current p.
  - Covered when all w>=0 (neg=0) or all w<=0 (neg=1). Edges are inclusive; there is no top-left rule.
  - A covered pixel is loaded into the output register and pix_valid is set.
  - Scanner order: x increments; at xmax, x returns to xmin and y increments.
  - After (xmax,ymax) is evaluated, go to DRAIN.
- **Advance condition**: !pix_valid || pix_ready. When it is false, the scanner and output register hold.
- **DRAIN**
  - Wait until pix_valid==0 or the final handshake completes, then go to DONE.
- **DONE** (1 cycle)
  - done=1, then go to IDLE.
- While busy, tri_valid is ignored. Vertex inputs are only sampled on accept.

## Timing
- Reset values:
  - state=IDLE; pix_valid=0; pix_x=pix_y=0; busy=0; done=0.
  - tri_ready=0 in any cycle rst is high, and 1 in the first cycle after rst deasserts.
- Accept in cycle 0. SETUP is cycle 1. The first pixel is evaluated in cycle 2.
- If the first pixel is covered, pix_valid rises in cycle 3.
- Throughput is one bbox pixel per cycle when unstalled. Uncovered pixels consume a cycle but produce no output.
- pix_x/pix_y stay stable while pix_valid && !pix_ready.
- Degenerate or off-screen triangle: done is asserted in cycle 2 and tri_ready in cycle 3.
- Normal triangle: done is asserted one cycle after the last pixel handshake, or one cycle after the last evaluation if the last pixel is uncovered and the output register is empty.
- Reset mid-operation: the next cycle returns to IDLE, clears pix_valid and drops any queued pixel; no done pulse.

## Structure
- Shared package raster_pkg holds:
  - the state encoding;
  - COORD_W=16 and EDGE_W=36;
  - default SCREEN_W/SCREEN_H;
  - the edge function as a reusable function.
- Sub-module bbox_scanner owns the x/y counters. Its interface is load, advance, the bbox bounds, current x/y and a last flag.
- The FSM, coverage test and output register live in tri_raster_ctrl.

## Test plan
- **Basic coverage**: v=(0,0),(4,0),(0,4) with pix_ready=1.
  - Exactly 15 pixels, row-major: (0,0)..(4,0), (0,1)..(3,1), …, (0,4).
  - One done pulse. First pix_valid in cycle 3.
- **Winding independence**: same triangle with v1 and v2 swapped (area=-16).
  - Identical 15 pixels in identical order.
- **Degenerate**: collinear (0,0),(2,2),(4,4).
  - pix_valid never asserts. done=1 in cycle 2, tri_ready=1 in cycle 3.
- **Backpressure**: first test with pix_ready low for 10 cycles after the 4th pixel.
  - Pixel held stable throughout.
  - 15 unique pixels in order, none lost or duplicated.
- **Clamping**: (-5,-5),(400,-5),(-5,300) on 320x240.
  - First pixel is (0,0). No coordinate exceeds (319,239).
  - Pixel count matches the software model. tri_ready stays low until done.
- **Reset mid-scan**: rst for 1 cycle after the 3rd pixel handshake of the first test.
  - Next cycle: pix_valid=0, busy=0, no done.
  - A new triangle (0,0),(1,0),(0,1) then yields exactly (0,0),(1,0),(0,1).
